control_cmd_dispatch: RTL and testbench
=======================================

Name: control_cmd_dispatch

Overview:
Command front end directly upstream of control_cmd_readpixel and its sibling sub-command blocks. Takes the synchronized receive byte stream, decodes the leading opcode byte, and selects one sub-command. It forwards every following byte to that sub-command as data plus a one-cycle enable pulse, until the sub-command raises done. It also guards against unknown opcodes and runaway commands.

Parameters:
NUM_SUBCMDS, 4, number of sub-command slots; slot index = position in cmd::OPCODE_TABLE.
MAX_CMD_BYTES, 1024, payload bytes forwarded without done before abort; must be >= 2.
TIMEOUT_CYCLES, 65535, idle clk cycles between payload bytes before abort (only with CMD_TIMEOUT_EN).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low
rx_data  in  8  received byte, valid when rx_valid=1
rx_valid  in  1  one-clk pulse per byte, already in clk domain
subcmd_data  out  8  byte presented to sub-commands; drives data_in of each
subcmd_enable  out  NUM_SUBCMDS  one-hot one-clk pulse per forwarded byte; drives enable
subcmd_done  in  NUM_SUBCMDS  done pulses from sub-commands
subcmd_abort  out  1  one-clk pulse; sub-commands return to their idle state
busy  out  1  high while a command is in progress
cmd_done  out  1  one-clk pulse when the selected sub-command completes
err_opcode  out  1  one-clk pulse on unknown opcode
err_abort  out  1  one-clk pulse on length overflow or timeout

Behaviour:
- Reset (reset=0, async): state IDLE. subcmd_data=0, subcmd_enable=0, subcmd_abort=0, busy=0, cmd_done=0, err_opcode=0, err_abort=0. Byte counter, select register and timer = 0. Reset mid-command discards everything, with no pulses.
- States: IDLE, ACTIVE.
- IDLE + rx_valid:
  - Look up rx_data with cmd::opcode_to_slot().
  - 8'h00 is a NOP: ignored, no error.
  - Known opcode: latch slot into sel, clear counter, go to ACTIVE; busy=1 from the next cycle. No enable pulse for the opcode byte.
  - Unknown opcode: err_opcode pulses next cycle; stay in IDLE.
- ACTIVE + rx_valid:
  - Next cycle: subcmd_data<=rx_data and subcmd_enable[sel]<=1 for exactly one cycle (latency 1). All other bits stay 0.
  - subcmd_data holds its value until the next forwarded byte.
  - Counter increments, saturating at MAX_CMD_BYTES.
- ACTIVE + subcmd_done[sel]:
  - cmd_done pulses next cycle; go to IDLE; busy=0 next cycle.
  - done bits from non-selected slots are ignored.
- Same-cycle subcmd_done[sel] and rx_valid: the completion is taken and the byte is not forwarded; it is decoded as the next opcode, exactly as in IDLE.
- Overflow: a byte arriving in ACTIVE with counter == MAX_CMD_BYTES is not forwarded. err_abort and subcmd_abort pulse next cycle; go to IDLE.
- rx_valid is sampled only on a cycle where it is high; back-to-back rx_valid pulses are legal. Each produces its own enable pulse on consecutive cycles.
- Widths: counter is $clog2(MAX_CMD_BYTES+1) bits; sel is $clog2(NUM_SUBCMDS) bits, minimum 1.

Optional Feature:
CMD_TIMEOUT_EN.
- Defined: in ACTIVE, a timer counts clk cycles since the last rx_valid and resets on each byte. When it reaches TIMEOUT_CYCLES: err_abort and subcmd_abort pulse, go to IDLE. A subcmd_done on the same cycle wins (normal completion, no error).
- Undefined: no timer, and TIMEOUT_CYCLES is unused. ACTIVE exits only on done, overflow or reset.

Decomposition:
- Package cmd: opcode_t (8 bits), OPCODE_TABLE constant, and the opcode_to_slot() function returning valid bit + slot. Opcodes: OPC_READPIXEL=8'h50 at slot 0, OPC_READROW=8'h52 at slot 1, OPC_FILLRECT=8'h46 at slot 2, OPC_BRIGHTNESS=8'h54 at slot 3.
- Package types: dispatch_state_t enum.
- No sub-module; the timer stays inline.

Test Plan:
- 8'h50, 8'h05, 8'h10, 8'h00, 8'hAA, 8'hBB (BYTES_PER_PIXEL=2), with control_cmd_readpixel attached -> five subcmd_enable[0] pulses, each 1 clk after its rx_valid; subcmd_data sequence 05,10,00,AA,BB; one cmd_done; busy 1->0.
- 8'h7E in IDLE -> err_opcode pulse; subcmd_enable stays 0; busy=0. 8'h00 in IDLE -> no pulses.
- MAX_CMD_BYTES=4, opcode 8'h52 followed by 5 bytes, done held low -> 4 enable[1] pulses; the 5th byte produces err_abort and subcmd_abort and no enable.
- done[0] and rx_valid carrying 8'h46 on the same cycle while in ACTIVE with slot 0 -> cmd_done; slot 2 selected; the next byte pulses enable[2].
- reset driven low mid-payload after 2 bytes -> all outputs 0 immediately; after release, 8'h50 starts a fresh command with the counter at 0.
- With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=20: opcode 8'h54, then a 25-cycle gap -> err_abort and subcmd_abort at cycle 20. Without the macro: no abort, busy stays 1.

Source files
------------

// File: rtl/control_cmd_dispatch_pkg.sv
// Opcode table, slot lookup and dispatch FSM state type shared by the command front end.
// Pure declarations: no latency, no flow control.
package cmd;
    typedef logic [7:0] opcode_t;

    localparam int      NUM_OPCODES    = 4;
    localparam opcode_t OPC_NOP        = 8'h00;
    localparam opcode_t OPC_READPIXEL  = 8'h50;
    localparam opcode_t OPC_READROW    = 8'h52;
    localparam opcode_t OPC_FILLRECT   = 8'h46;
    localparam opcode_t OPC_BRIGHTNESS = 8'h54;

    // Slot index is the position in this table.
    localparam opcode_t OPCODE_TABLE [NUM_OPCODES] = '{
        OPC_READPIXEL, OPC_READROW, OPC_FILLRECT, OPC_BRIGHTNESS
    };

    typedef struct packed {
        logic       vld;
        logic [1:0] slot;
    } slot_lookup_t;

    function automatic slot_lookup_t opcode_to_slot(input opcode_t opc);
        slot_lookup_t r;
        r = '0;
        for (int i = 0; i < NUM_OPCODES; i++) begin
            if (OPCODE_TABLE[i] == opc) begin
                r.vld  = 1'b1;
                r.slot = 2'(i);
            end
        end
        return r;
    endfunction
endpackage

package types;
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } dispatch_state_t;
endpackage

// File: rtl/control_cmd_dispatch.sv
// Decodes the leading opcode byte and forwards payload bytes to the selected sub-command until done.
// Latency: 1 clk from rx_valid to subcmd_enable / status pulses. No backpressure: every rx byte is consumed.
// Optional inter-byte timeout abort when CMD_TIMEOUT_EN is defined.
module control_cmd_dispatch
    import cmd::*;
    import types::*;
#(
    parameter int NUM_SUBCMDS    = 4,
    parameter int MAX_CMD_BYTES  = 1024,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             subcmd_data,
    output logic [NUM_SUBCMDS-1:0] subcmd_enable,
    input  logic [NUM_SUBCMDS-1:0] subcmd_done,
    output logic                   subcmd_abort,
    output logic                   busy,
    output logic                   cmd_done,
    output logic                   err_opcode,
    output logic                   err_abort
);
    localparam int SEL_W = (NUM_SUBCMDS > 1) ? $clog2(NUM_SUBCMDS) : 1;
    localparam int CNT_W = $clog2(MAX_CMD_BYTES + 1);

    dispatch_state_t  r_state;
    logic [SEL_W-1:0] r_sel;
    logic [CNT_W-1:0] r_cnt;

    slot_lookup_t w_lookup;
    logic         w_active;
    logic         w_known;
    logic         w_nop;
    logic         w_sel_done;
    logic         w_decode;
    logic         w_payload;
    logic         w_overflow;
    logic         w_timeout;

    assign w_lookup   = opcode_to_slot(rx_data);
    assign w_nop      = (rx_data == OPC_NOP);
    assign w_known    = w_lookup.vld && (int'(w_lookup.slot) < NUM_SUBCMDS);
    assign w_active   = (r_state == ST_ACTIVE);
    assign w_sel_done = w_active && subcmd_done[r_sel];
    // A byte landing with the completion is the next opcode, not payload.
    assign w_decode   = rx_valid && (!w_active || w_sel_done);
    assign w_payload  = rx_valid && w_active && !w_sel_done;
    assign w_overflow = w_payload && (r_cnt == CNT_W'(MAX_CMD_BYTES));

`ifdef CMD_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] r_timer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (!w_active || rx_valid) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    assign w_timeout = w_active && !w_sel_done && !rx_valid &&
                       (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
`endif

    assign busy = w_active;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_sel         <= '0;
            r_cnt         <= '0;
            subcmd_data   <= '0;
            subcmd_enable <= '0;
            subcmd_abort  <= 1'b0;
            cmd_done      <= 1'b0;
            err_opcode    <= 1'b0;
            err_abort     <= 1'b0;
        end else begin
            subcmd_enable <= '0;
            subcmd_abort  <= 1'b0;
            cmd_done      <= 1'b0;
            err_opcode    <= 1'b0;
            err_abort     <= 1'b0;

            if (w_sel_done) begin
                cmd_done <= 1'b1;
                r_state  <= ST_IDLE;
            end

            if (w_decode) begin
                if (!w_nop) begin
                    if (w_known) begin
                        r_state <= ST_ACTIVE;
                        r_sel   <= SEL_W'(w_lookup.slot);
                        r_cnt   <= '0;
                    end else begin
                        err_opcode <= 1'b1;
                    end
                end
            end else if (w_overflow || w_timeout) begin
                err_abort    <= 1'b1;
                subcmd_abort <= 1'b1;
                r_state      <= ST_IDLE;
            end else if (w_payload) begin
                subcmd_data          <= rx_data;
                subcmd_enable[r_sel] <= 1'b1;
                r_cnt                <= r_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_control_cmd_dispatch.sv
// Bench for control_cmd_dispatch: fixed vector table, reset/timeout sequences, then random traffic vs a reference model.
module tb_control_cmd_dispatch;
    localparam int NS   = 4;
    localparam int MAXB = 5;
    localparam int TO   = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic [7:0]    subcmd_data;
    logic [NS-1:0] subcmd_enable;
    logic [NS-1:0] subcmd_done = '0;
    logic          subcmd_abort;
    logic          busy;
    logic          cmd_done;
    logic          err_opcode;
    logic          err_abort;

    always #5 clk = ~clk;

    control_cmd_dispatch #(
        .NUM_SUBCMDS(NS), .MAX_CMD_BYTES(MAXB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .subcmd_data(subcmd_data), .subcmd_enable(subcmd_enable),
        .subcmd_done(subcmd_done), .subcmd_abort(subcmd_abort), .busy(busy),
        .cmd_done(cmd_done), .err_opcode(err_opcode), .err_abort(err_abort)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: command-level view (in a command or not, which slot, bytes taken, idle gap).
    bit         m_active = 0;
    int         m_sel = 0;
    int         m_cnt = 0;
    int         m_gap = 0;
    logic [7:0] m_data = '0;
    logic [16:0] m_exp = '0;
    logic [7:0] opc_list [4] = '{8'h50, 8'h52, 8'h46, 8'h54};

    typedef struct {
        logic        rxv;
        logic [7:0]  rxd;
        logic [3:0]  done;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl [22];

    function automatic logic [16:0] pack_out(input logic [7:0] d, input logic [3:0] en,
                                             input logic ab, input logic bz, input logic cd,
                                             input logic eo, input logic ea);
        return {d, en, ab, bz, cd, eo, ea};
    endfunction

    function automatic vec_t mkv(input logic rxv, input logic [7:0] rxd, input logic [3:0] done,
                                 input logic [7:0] d, input logic [3:0] en, input logic ab,
                                 input logic bz, input logic cd, input logic eo, input logic ea);
        vec_t v;
        v.rxv  = rxv;
        v.rxd  = rxd;
        v.done = done;
        v.exp  = pack_out(d, en, ab, bz, cd, eo, ea);
        return v;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_sel    = 0;
        m_cnt    = 0;
        m_gap    = 0;
        m_data   = '0;
    endtask

    task automatic model_step(input logic rxv, input logic [7:0] rxd, input logic [3:0] done);
        logic [3:0] en;
        logic ab, cd, eo, ea;
        bit decode;
        en = '0; ab = 0; cd = 0; eo = 0; ea = 0; decode = 0;
        if (m_active) begin
            if (done[m_sel]) begin
                cd = 1; m_active = 0; decode = rxv;
            end else if (rxv) begin
                m_gap = 0;
                if (m_cnt >= MAXB) begin
                    ab = 1; ea = 1; m_active = 0;
                end else begin
                    en[m_sel] = 1; m_data = rxd; m_cnt++;
                end
            end else begin
`ifdef CMD_TIMEOUT_EN
                m_gap++;
                if (m_gap >= TO) begin
                    ab = 1; ea = 1; m_active = 0;
                end
`endif
            end
        end else begin
            decode = rxv;
        end
        if (decode && rxd != 8'h00) begin
            int idx;
            idx = -1;
            for (int i = 0; i < 4; i++) if (opc_list[i] == rxd) idx = i;
            if (idx >= 0) begin
                m_active = 1; m_sel = idx; m_cnt = 0; m_gap = 0;
            end else begin
                eo = 1;
            end
        end
        m_exp = pack_out(m_data, en, ab, m_active, cd, eo, ea);
    endtask

    task automatic check(input string name, input logic [16:0] exp);
        logic [16:0] act;
        act = {subcmd_data, subcmd_enable, subcmd_abort, busy, cmd_done, err_opcode, err_abort};
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got data=%h en=%b abort=%b busy=%b done=%b err_op=%b err_ab=%b, want data=%h en=%b abort=%b busy=%b done=%b err_op=%b err_ab=%b",
                     name, $time, act[16:9], act[8:5], act[4], act[3], act[2], act[1], act[0],
                     exp[16:9], exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input string name, input logic rxv, input logic [7:0] rxd, input logic [3:0] done);
        rx_valid    = rxv;
        rx_data     = rxd;
        subcmd_done = done;
        model_step(rxv, rxd, done);
        @(posedge clk);
        #1;
        rx_valid    = 1'b0;
        subcmd_done = '0;
        check(name, m_exp);
    endtask

    initial begin
        // data, en, abort, busy, cmd_done, err_op, err_abort
        tbl[0]  = mkv(1, 8'h50, 4'h0, 8'h00, 4'h0, 0, 1, 0, 0, 0);
        tbl[1]  = mkv(1, 8'h05, 4'h0, 8'h05, 4'h1, 0, 1, 0, 0, 0);
        tbl[2]  = mkv(1, 8'h10, 4'h0, 8'h10, 4'h1, 0, 1, 0, 0, 0);
        tbl[3]  = mkv(1, 8'h00, 4'h0, 8'h00, 4'h1, 0, 1, 0, 0, 0);
        tbl[4]  = mkv(1, 8'hAA, 4'h0, 8'hAA, 4'h1, 0, 1, 0, 0, 0);
        tbl[5]  = mkv(1, 8'hBB, 4'h0, 8'hBB, 4'h1, 0, 1, 0, 0, 0);
        tbl[6]  = mkv(0, 8'h00, 4'h1, 8'hBB, 4'h0, 0, 0, 1, 0, 0);
        tbl[7]  = mkv(1, 8'h7E, 4'h0, 8'hBB, 4'h0, 0, 0, 0, 1, 0);
        tbl[8]  = mkv(1, 8'h00, 4'h0, 8'hBB, 4'h0, 0, 0, 0, 0, 0);
        tbl[9]  = mkv(1, 8'h52, 4'h0, 8'hBB, 4'h0, 0, 1, 0, 0, 0);
        tbl[10] = mkv(1, 8'h01, 4'h0, 8'h01, 4'h2, 0, 1, 0, 0, 0);
        tbl[11] = mkv(1, 8'h02, 4'h0, 8'h02, 4'h2, 0, 1, 0, 0, 0);
        tbl[12] = mkv(1, 8'h03, 4'h0, 8'h03, 4'h2, 0, 1, 0, 0, 0);
        tbl[13] = mkv(1, 8'h04, 4'h0, 8'h04, 4'h2, 0, 1, 0, 0, 0);
        tbl[14] = mkv(1, 8'h05, 4'h0, 8'h05, 4'h2, 0, 1, 0, 0, 0);
        tbl[15] = mkv(1, 8'h06, 4'h0, 8'h05, 4'h0, 1, 0, 0, 0, 1);
        tbl[16] = mkv(1, 8'h50, 4'h0, 8'h05, 4'h0, 0, 1, 0, 0, 0);
        tbl[17] = mkv(1, 8'h11, 4'h0, 8'h11, 4'h1, 0, 1, 0, 0, 0);
        tbl[18] = mkv(0, 8'h00, 4'h4, 8'h11, 4'h0, 0, 1, 0, 0, 0);
        tbl[19] = mkv(1, 8'h46, 4'h1, 8'h11, 4'h0, 0, 1, 1, 0, 0);
        tbl[20] = mkv(1, 8'h22, 4'h0, 8'h22, 4'h4, 0, 1, 0, 0, 0);
        tbl[21] = mkv(1, 8'h7E, 4'h4, 8'h22, 4'h0, 0, 0, 1, 1, 0);

        #2 reset = 1'b0;
        #1 check("reset_init", '0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();

        for (int i = 0; i < 22; i++) begin
            rx_valid    = tbl[i].rxv;
            rx_data     = tbl[i].rxd;
            subcmd_done = tbl[i].done;
            model_step(tbl[i].rxv, tbl[i].rxd, tbl[i].done);
            @(posedge clk);
            #1;
            rx_valid    = 1'b0;
            subcmd_done = '0;
            check($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Inter-byte gap: aborts after TO idle cycles only when the timeout is built in.
        step("timeout_op", 1, 8'h54, 4'h0);
        for (int i = 0; i < 25; i++) step($sformatf("timeout_gap[%0d]", i), 0, 8'h00, 4'h0);
        step("timeout_close", 0, 8'h00, 4'h8);

        // Reset mid-payload, then a fresh command must get the full byte allowance.
        step("rst_op", 1, 8'h50, 4'h0);
        step("rst_b0", 1, 8'h01, 4'h0);
        step("rst_b1", 1, 8'h02, 4'h0);
        reset = 1'b0;
        #1 check("reset_mid", '0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 check("reset_hold", '0);
        reset = 1'b1;
        step("fresh_op", 1, 8'h50, 4'h0);
        for (int i = 0; i < MAXB; i++) step($sformatf("fresh_b%0d", i), 1, 8'(8'h30 + i), 4'h0);
        step("fresh_overflow", 1, 8'h99, 4'h0);

        for (int i = 0; i < 600; i++) begin
            logic       rxv;
            logic [7:0] rxd;
            logic [3:0] done;
            int         r;
            rxv = ($urandom_range(0, 99) < 55);
            r   = $urandom_range(0, 9);
            if (r < 3)       rxd = opc_list[$urandom_range(0, 3)];
            else if (r == 3) rxd = 8'h00;
            else             rxd = 8'($urandom);
            done = ($urandom_range(0, 99) < 8) ? 4'($urandom_range(1, 15)) : 4'h0;
            step($sformatf("rand[%0d]", i), rxv, rxd, done);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
